// File: rtl/mips_bus_arbiter_if.sv
// Bundled request/response signals between the CPU's fetch and load/store ports,
// the arbiter, and the single external Avalon-style memory port.
interface mips_bus_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();
   // fetch port
   logic [ADDR_W-1:0]   i_address;
   logic                i_read;
   logic                i_waitrequest;
   logic [DATA_W-1:0]   i_readdata;
   // load/store port
   logic [ADDR_W-1:0]   d_address;
   logic                d_read;
   logic                d_write;
   logic [DATA_W-1:0]   d_writedata;
   logic [DATA_W/8-1:0] d_byteenable;
   logic                d_waitrequest;
   logic [DATA_W-1:0]   d_readdata;
   // memory port
   logic [ADDR_W-1:0]   bus_address;
   logic                bus_read;
   logic                bus_write;
   logic [DATA_W-1:0]   bus_writedata;
   logic [DATA_W/8-1:0] bus_byteenable;
   logic                bus_waitrequest;
   logic [DATA_W-1:0]   bus_readdata;

   // Arbiter side: takes both CPU requests and the memory response, drives the rest.
   modport slave (
      input  i_address, i_read, d_address, d_read, d_write, d_writedata, d_byteenable,
             bus_waitrequest, bus_readdata,
      output i_waitrequest, i_readdata, d_waitrequest, d_readdata,
             bus_address, bus_read, bus_write, bus_writedata, bus_byteenable
   );

   // Environment side: the CPU core plus the external memory.
   modport master (
      output i_address, i_read, d_address, d_read, d_write, d_writedata, d_byteenable,
             bus_waitrequest, bus_readdata,
      input  i_waitrequest, i_readdata, d_waitrequest, d_readdata,
             bus_address, bus_read, bus_write, bus_writedata, bus_byteenable
   );
endinterface

// File: rtl/mips_bus_arbiter.sv
// Two-master (fetch, load/store) to one-slave bus arbiter for mips_cpu_bus.
// Optional ARB_ROUND_ROBIN_EN: alternate grants on contention instead of data-first priority.
module mips_bus_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   mips_bus_arbiter_if.slave     bus,
   output logic [1:0]            grant
);
   localparam logic [ADDR_W-1:0]   ZERO_ADDR = '0;
   localparam logic [DATA_W-1:0]   ZERO_DATA = '0;
   localparam logic [DATA_W/8-1:0] ZERO_BE   = '0;
   localparam logic [DATA_W/8-1:0] ALL_LANES = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GNT_I = 2'b01,
      GNT_D = 2'b10
   } state_t;

   state_t state, state_next;
   logic   i_req, d_req;
   logic   pick_data;

   assign i_req = bus.i_read;
   assign d_req = bus.d_read | bus.d_write;

   // Both masters see the memory data; only the granted one treats it as valid.
   assign bus.i_readdata = bus.bus_readdata;
   assign bus.d_readdata = bus.bus_readdata;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         grant <= 2'b00;
      end else begin
         state <= state_next;
         grant <= state_next;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   // Owner of the most recent completed transfer: 0 = fetch, 1 = data.
   logic last;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last <= 1'b0;
      end else if (state == GNT_I && i_req && !bus.bus_waitrequest) begin
         last <= 1'b0;
      end else if (state == GNT_D && d_req && !bus.bus_waitrequest) begin
         last <= 1'b1;
      end
   end

   assign pick_data = ~last;
`else
   assign pick_data = 1'b1;
`endif

   // NOTE: every output and next-state gets a default before the case so no
   // path leaves a signal unassigned, which would infer a latch.
   always_comb begin
      state_next          = state;
      bus.bus_address     = ZERO_ADDR;
      bus.bus_read        = 1'b0;
      bus.bus_write       = 1'b0;
      bus.bus_writedata   = ZERO_DATA;
      bus.bus_byteenable  = ZERO_BE;
      bus.i_waitrequest   = 1'b1;
      bus.d_waitrequest   = 1'b1;

      case (state)
         IDLE: begin
            if (d_req && (!i_req || pick_data)) begin
               state_next = GNT_D;
            end else if (i_req) begin
               state_next = GNT_I;
            end
         end

         GNT_I: begin
            bus.bus_address    = bus.i_address;
            bus.bus_read       = bus.i_read;
            bus.bus_byteenable = ALL_LANES;
            bus.i_waitrequest  = bus.bus_waitrequest;
            // Leave on completion or on request withdrawal.
            if (!i_req || !bus.bus_waitrequest) begin
               state_next = IDLE;
            end
         end

         GNT_D: begin
            bus.bus_address    = bus.d_address;
            bus.bus_write      = bus.d_write;
            bus.bus_read       = bus.d_read & ~bus.d_write;  // write wins
            bus.bus_writedata  = bus.d_writedata;
            bus.bus_byteenable = bus.d_byteenable;
            bus.d_waitrequest  = bus.bus_waitrequest;
            if (!d_req || !bus.bus_waitrequest) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter: directed vector table, hand-written
// reset/contention sequences, and randomized traffic against a transaction-level model.
module tb_mips_bus_arbiter;
   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] grant;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   mips_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif ();

   mips_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif.slave),
      .grant (grant)
   );

   typedef struct {
      logic        i_rd, d_rd, d_wr, bw;
      logic [1:0]  g;
      logic        rd, wr, iw, dw;
      logic [31:0] addr, wdata;
      logic [3:0]  be;
   } vec_t;

   vec_t vecs[15];

   // Transaction-level model: who owns the bus (0 none, 1 fetch, 2 data)
   // and who finished last (used only for round-robin contention).
   int   m_owner;
   int   m_last;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic drive(input logic i_rd, input logic d_rd, input logic d_wr, input logic bw);
      bif.i_read          = i_rd;
      bif.d_read          = d_rd;
      bif.d_write         = d_wr;
      bif.bus_waitrequest = bw;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic model_step(input logic i_rd, input logic d_rd, input logic d_wr, input logic bw);
      logic i_req, d_req, own_req;
      i_req = i_rd;
      d_req = d_rd | d_wr;
      if (m_owner == 0) begin
         if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            m_owner = (m_last == 2) ? 1 : 2;
`else
            m_owner = 2;
`endif
         end else if (d_req) m_owner = 2;
         else if (i_req)     m_owner = 1;
      end else begin
         own_req = (m_owner == 1) ? i_req : d_req;
         if (!own_req) m_owner = 0;
         else if (!bw) begin
            m_last  = m_owner;
            m_owner = 0;
         end
      end
   endtask

   task automatic model_compare();
      logic [1:0]  e_g;
      logic        e_rd, e_wr, e_iw, e_dw;
      logic [31:0] e_addr, e_wdata;
      logic [3:0]  e_be;
      e_g = 2'b00; e_rd = 1'b0; e_wr = 1'b0; e_iw = 1'b1; e_dw = 1'b1;
      e_addr = '0; e_wdata = '0; e_be = '0;
      if (m_owner == 1) begin
         e_g = 2'b01; e_addr = bif.i_address; e_rd = bif.i_read; e_be = 4'hF;
         e_iw = bif.bus_waitrequest;
      end else if (m_owner == 2) begin
         e_g = 2'b10; e_addr = bif.d_address; e_wr = bif.d_write;
         e_rd = bif.d_read & ~bif.d_write; e_wdata = bif.d_writedata;
         e_be = bif.d_byteenable; e_dw = bif.bus_waitrequest;
      end
      check("rnd_grant", 64'(grant), 64'(e_g));
      check("rnd_ctrl", 64'({bif.bus_read, bif.bus_write, bif.i_waitrequest, bif.d_waitrequest}),
            64'({e_rd, e_wr, e_iw, e_dw}));
      check("rnd_addr", 64'(bif.bus_address), 64'(e_addr));
      check("rnd_wdata", 64'(bif.bus_writedata), 64'(e_wdata));
      check("rnd_be", 64'(bif.bus_byteenable), 64'(e_be));
      check("rnd_rdata", 64'({bif.i_readdata, bif.d_readdata}),
            64'({bif.bus_readdata, bif.bus_readdata}));
   endtask

   initial begin
      // Directed table: rows are consecutive cycles starting in IDLE.
      //           i  dr dw bw   g      rd wr iw dw  addr   wdata         be
      vecs[0]  = '{0, 0, 0, 0, 2'b00, 0, 0, 1, 1, 32'h0,  32'h0,        4'h0};
      vecs[1]  = '{1, 0, 0, 0, 2'b00, 0, 0, 1, 1, 32'h0,  32'h0,        4'h0};
      vecs[2]  = '{1, 0, 0, 0, 2'b01, 1, 0, 0, 1, 32'h4,  32'h0,        4'hF};
      vecs[3]  = '{0, 0, 0, 0, 2'b00, 0, 0, 1, 1, 32'h0,  32'h0,        4'h0};
      vecs[4]  = '{0, 0, 1, 1, 2'b00, 0, 0, 1, 1, 32'h0,  32'h0,        4'h0};
      vecs[5]  = '{0, 0, 1, 1, 2'b10, 0, 1, 1, 1, 32'h10, 32'hDEADBEEF, 4'hF};
      vecs[6]  = '{0, 0, 1, 1, 2'b10, 0, 1, 1, 1, 32'h10, 32'hDEADBEEF, 4'hF};
      vecs[7]  = '{0, 0, 1, 1, 2'b10, 0, 1, 1, 1, 32'h10, 32'hDEADBEEF, 4'hF};
      vecs[8]  = '{0, 0, 1, 0, 2'b10, 0, 1, 1, 0, 32'h10, 32'hDEADBEEF, 4'hF};
      vecs[9]  = '{0, 1, 1, 0, 2'b00, 0, 0, 1, 1, 32'h0,  32'h0,        4'h0};
      vecs[10] = '{0, 1, 1, 0, 2'b10, 0, 1, 1, 0, 32'h10, 32'hDEADBEEF, 4'hF};
      vecs[11] = '{0, 1, 0, 1, 2'b00, 0, 0, 1, 1, 32'h0,  32'h0,        4'h0};
      vecs[12] = '{0, 1, 0, 1, 2'b10, 1, 0, 1, 1, 32'h10, 32'hDEADBEEF, 4'hF};
      vecs[13] = '{0, 0, 0, 1, 2'b10, 0, 0, 1, 1, 32'h10, 32'hDEADBEEF, 4'hF};
      vecs[14] = '{0, 0, 0, 0, 2'b00, 0, 0, 1, 1, 32'h0,  32'h0,        4'h0};

      reset              = 1'b1;
      bif.i_address      = 32'h0000_0004;
      bif.d_address      = 32'h0000_0010;
      bif.d_writedata    = 32'hDEAD_BEEF;
      bif.d_byteenable   = 4'hF;
      bif.bus_readdata   = 32'h0022_1820;
      drive(0, 0, 0, 0);
      #3;
      check("reset_grant", 64'(grant), 64'(2'b00));
      check("reset_ctrl", 64'({bif.bus_read, bif.bus_write, bif.i_waitrequest, bif.d_waitrequest}),
            64'(4'b0011));
      check("reset_addr", 64'(bif.bus_address), 64'(0));
      next_cycle();
      reset = 1'b0;

      for (int i = 0; i < 15; i++) begin
         drive(vecs[i].i_rd, vecs[i].d_rd, vecs[i].d_wr, vecs[i].bw);
         @(negedge clk);
         check($sformatf("vec%0d_grant", i), 64'(grant), 64'(vecs[i].g));
         check($sformatf("vec%0d_ctrl", i),
               64'({bif.bus_read, bif.bus_write, bif.i_waitrequest, bif.d_waitrequest}),
               64'({vecs[i].rd, vecs[i].wr, vecs[i].iw, vecs[i].dw}));
         check($sformatf("vec%0d_addr", i), 64'(bif.bus_address), 64'(vecs[i].addr));
         check($sformatf("vec%0d_wdata", i), 64'(bif.bus_writedata), 64'(vecs[i].wdata));
         check($sformatf("vec%0d_be", i), 64'(bif.bus_byteenable), 64'(vecs[i].be));
         check($sformatf("vec%0d_irdata", i), 64'(bif.i_readdata), 64'(32'h0022_1820));
         next_cycle();
      end

      // Reset asserted mid-transfer while the slave stalls a store.
      drive(0, 0, 1, 1);
      next_cycle();
      check("midrst_pre_write", 64'(bif.bus_write), 64'(1));
      reset = 1'b1;
      #1;
      check("midrst_write", 64'(bif.bus_write), 64'(0));
      check("midrst_grant", 64'(grant), 64'(2'b00));
      check("midrst_waits", 64'({bif.i_waitrequest, bif.d_waitrequest}), 64'(2'b11));
      drive(0, 0, 0, 0);
      next_cycle();
      reset = 1'b0;

      // Persistent contention, zero-wait slave, fresh reset state.
      drive(1, 1, 0, 0);
      for (int c = 0; c < 8; c++) begin
         logic [1:0] exp_g;
         if (c % 2 == 0) exp_g = 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
         else exp_g = (c % 4 == 1) ? 2'b10 : 2'b01;
`else
         else exp_g = 2'b10;
`endif
         @(negedge clk);
         check($sformatf("contend%0d_grant", c), 64'(grant), 64'(exp_g));
         next_cycle();
      end
      drive(0, 0, 0, 0);
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;

      // Randomized traffic against the model.
      m_owner = 0;
      m_last  = 1;
      for (int n = 0; n < 400; n++) begin
         logic i_rd, d_rd, d_wr, bw;
         i_rd = bif.i_read ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 40);
         if (bif.d_read | bif.d_write) begin
            d_rd = ($urandom_range(0, 99) < 85) ? bif.d_read : 1'b0;
            d_wr = ($urandom_range(0, 99) < 85) ? bif.d_write : 1'b0;
         end else begin
            d_rd = ($urandom_range(0, 99) < 30);
            d_wr = ($urandom_range(0, 99) < 25);
         end
         bw = ($urandom_range(0, 99) < 40);
         drive(i_rd, d_rd, d_wr, bw);
         bif.i_address    = $urandom;
         bif.d_address    = $urandom;
         bif.d_writedata  = $urandom;
         bif.d_byteenable = 4'($urandom);
         bif.bus_readdata = $urandom;
         @(negedge clk);
         model_compare();
         next_cycle();
         model_step(bif.i_read, bif.d_read, bif.d_write, bif.bus_waitrequest);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
